picomips_core: RTL and testbench

Parametrised second-generation picoMIPS execution core. It has a generalised data width, program depth and register-file size. It adds a synchronous, edge-detected switch handshake (WAIT), branches, a fractional multiply, a switch load, an explicit display write and a HALT state. Program memory is external: the core drives prog_addr and consumes instr combinationally in the same cycle. It sits between the board switches/LEDs and the program ROM.

---
 rtl/picomips_core.sv | 194 +++++++++++++++++++
 tb/tb_picomips_core.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/picomips_core.sv
// picomips_core: parametrised picoMIPS execution core.
// One instruction per cycle from an external combinational program ROM,
// with a synchronised sw8 release handshake (WAIT) and a terminal HALT state.
module picomips_core #(
    parameter int unsigned n     = 8,
    parameter int unsigned Psize = 5,
    parameter int unsigned Rsize = 3,
    localparam int unsigned Isize = 4 + 2 * Rsize + n
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [n-1:0]     sw,
    input  logic             sw8,
    input  logic [Isize-1:0] instr,
    output logic [Psize-1:0] prog_addr,
    output logic [n-1:0]     display,
    output logic             waiting,
    output logic             halted
);

    localparam int unsigned NREG = 2 ** Rsize;

    // Opcodes; 10..14 are unassigned and execute as NOP.
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_MULI = 4'd4;
    localparam logic [3:0] OP_LDSW = 4'd5;
    localparam logic [3:0] OP_WAIT = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8;
    localparam logic [3:0] OP_DISP = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [Psize-1:0] pc_q, pc_d;
    logic [n-1:0]     disp_q, disp_d;
    logic             waiting_q, halted_q;
    logic             s1_q, s2_q, s3_q;
    logic [n-1:0]     regs_q [NREG];

    logic [3:0]       opcode;
    logic [Rsize-1:0] rd_idx, rs_idx;
    logic [n-1:0]     imm;
    logic [n-1:0]     rd_val, rs_val;
    logic             release_c;
    logic             wr_en;
    logic [n-1:0]     wr_data;
    logic [Psize-1:0] pc_inc;

    logic signed [2*n-1:0] mul_a, mul_b, mul_p;
    logic [n-1:0]          mul_res;

    // Instruction field decode.
    assign opcode = instr[Isize-1 -: 4];
    assign rd_idx = instr[Isize-5 -: Rsize];
    assign rs_idx = instr[Isize-5-Rsize -: Rsize];
    assign imm    = instr[n-1:0];

    // Register 0 is hard-wired to zero on read.
    assign rd_val = (rd_idx == Rsize'(0)) ? '0 : regs_q[rd_idx];
    assign rs_val = (rs_idx == Rsize'(0)) ? '0 : regs_q[rs_idx];

    // One-cycle pulse on a synchronised falling edge of sw8.
    assign release_c = s3_q & ~s2_q;

    assign pc_inc = pc_q + Psize'(1);

    // Q1.(n-1) fractional multiply: keep product bits [2n-2:n-1].
    assign mul_a   = {{n{rd_val[n-1]}}, rd_val};
    assign mul_b   = {{n{imm[n-1]}}, imm};
    assign mul_p   = mul_a * mul_b;
    assign mul_res = n'(mul_p >>> (n - 1));

    // Next-state, PC, display and register write decode.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        disp_d  = disp_q;
        wr_en   = 1'b0;
        wr_data = rd_val;

        case (state_q)
            S_RUN: begin
                pc_d = pc_inc;
                case (opcode)
                    OP_NOP: ;
                    OP_ADD: begin
                        wr_en   = 1'b1;
                        wr_data = rd_val + rs_val;
                    end
                    OP_ADDI: begin
                        wr_en   = 1'b1;
                        wr_data = rd_val + imm;
                    end
                    OP_SUB: begin
                        wr_en   = 1'b1;
                        wr_data = rd_val - rs_val;
                    end
                    OP_MULI: begin
                        wr_en   = 1'b1;
                        wr_data = mul_res;
                    end
                    OP_LDSW: begin
                        wr_en   = 1'b1;
                        wr_data = sw;
                    end
                    OP_WAIT: begin
                        state_d = S_WAIT;
                        pc_d    = pc_q;
                    end
                    OP_BEQ: begin
                        if (rd_val == rs_val) begin
                            pc_d = Psize'(imm);
                        end
                    end
                    OP_JMP: begin
                        pc_d = Psize'(imm);
                    end
                    OP_DISP: begin
                        disp_d = rd_val;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end
            S_WAIT: begin
                if (release_c) begin
                    pc_d    = pc_inc;
                    state_d = S_RUN;
                end
            end
            S_HALT: ;
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // State, PC, display and status flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_RUN;
            pc_q      <= '0;
            disp_q    <= '0;
            waiting_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            disp_q    <= disp_d;
            waiting_q <= (state_d == S_WAIT);
            halted_q  <= (state_d == S_HALT);
        end
    end

    // Register file; writes to register 0 are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && (rd_idx != Rsize'(0))) begin
            regs_q[rd_idx] <= wr_data;
        end
    end

    // Two-flop synchroniser plus history flop for sw8 edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= sw8;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign prog_addr = pc_q;
    assign display   = disp_q;
    assign waiting   = waiting_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_picomips_core.sv
// Self-checking bench for picomips_core (default parameters) with an ISA-level model.
module tb_picomips_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  sw = 8'h00;
    logic        sw8 = 1'b1;
    logic [17:0] instr;
    logic [4:0]  prog_addr;
    logic [7:0]  display;
    logic        waiting;
    logic        halted;

    logic [17:0] prog [32];

    int checks = 0;
    int errors = 0;

    // ISA model state
    int m_regs [8];
    int m_pc, m_disp, m_st;   // m_st: 0 run, 1 wait, 2 halt
    bit m_s1, m_s2, m_s3;     // sampled sw8 history (newest first)

    picomips_core #(.n(8), .Psize(5), .Rsize(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .sw8       (sw8),
        .instr     (instr),
        .prog_addr (prog_addr),
        .display   (display),
        .waiting   (waiting),
        .halted    (halted)
    );

    assign instr = prog[prog_addr];

    always #5 clk = ~clk;

    function automatic logic [17:0] enc(int op, int rd, int rs, int imm);
        return {4'(op), 3'(rd), 3'(rs), 8'(imm)};
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the current inputs.
    task automatic m_step();
        int ins, op, rd, rs, imm, a, b, res, sa, si, pc_n, st_n;
        bit wr, pulse;
        if (reset) begin
            foreach (m_regs[i]) m_regs[i] = 0;
            m_pc = 0; m_disp = 0; m_st = 0;
            m_s1 = 1; m_s2 = 1; m_s3 = 1;
            return;
        end
        pulse = m_s3 && !m_s2;
        ins = int'(prog[m_pc]);
        op  = (ins >> 14) & 15;
        rd  = (ins >> 11) & 7;
        rs  = (ins >> 8) & 7;
        imm = ins & 255;
        a = m_regs[rd];
        b = m_regs[rs];
        wr = 0; res = 0;
        if (m_st == 0) begin
            pc_n = (m_pc + 1) % 32;
            st_n = 0;
            case (op)
                1: begin res = (a + b) & 255; wr = 1; end
                2: begin res = (a + imm) & 255; wr = 1; end
                3: begin res = (a - b) & 255; wr = 1; end
                4: begin
                    sa = (a >= 128) ? a - 256 : a;
                    si = (imm >= 128) ? imm - 256 : imm;
                    res = ((sa * si) >>> 7) & 255;
                    wr = 1;
                end
                5: begin res = int'(sw); wr = 1; end
                6: begin st_n = 1; pc_n = m_pc; end
                7: if (a == b) pc_n = imm % 32;
                8: pc_n = imm % 32;
                9: m_disp = a;
                15: begin st_n = 2; pc_n = m_pc; end
                default: ;
            endcase
            m_pc = pc_n;
            m_st = st_n;
            if (wr && rd != 0) m_regs[rd] = res;
        end else if (m_st == 1) begin
            if (pulse) begin
                m_pc = (m_pc + 1) % 32;
                m_st = 0;
            end
        end
        m_s3 = m_s2; m_s2 = m_s1; m_s1 = sw8;
    endtask

    // One clock: update model, let the edge happen, compare all outputs.
    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
        cmp("prog_addr", 32'(prog_addr), 32'(m_pc));
        cmp("display",   32'(display),   32'(m_disp));
        cmp("waiting",   32'(waiting),   32'(m_st == 1));
        cmp("halted",    32'(halted),    32'(m_st == 2));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_prog();
        foreach (prog[i]) prog[i] = '0;
    endtask

    initial begin
        // Arithmetic with wrap and r0 write discard
        clear_prog();
        prog[0] = enc(2, 1, 0, 8'h05);
        prog[1] = enc(2, 2, 0, 8'hFE);
        prog[2] = enc(1, 1, 2, 0);
        prog[3] = enc(9, 1, 0, 0);
        prog[4] = enc(2, 0, 0, 8'h7F);
        prog[5] = enc(9, 0, 0, 0);
        sw8 = 1'b1;
        do_reset();
        cmp("rst_pc", 32'(prog_addr), 0);
        cmp("rst_disp", 32'(display), 0);
        repeat (4) tick();
        cmp("add_wrap", 32'(display), 32'h03);
        repeat (2) tick();
        cmp("r0_zero", 32'(display), 32'h00);

        // Mid-program reset for one cycle clears everything
        prog[6] = enc(9, 2, 0, 0);
        tick();
        cmp("disp_r2", 32'(display), 32'hFE);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cmp("mrst_pc", 32'(prog_addr), 0);
        cmp("mrst_disp", 32'(display), 0);
        cmp("mrst_wait", 32'(waiting), 0);
        cmp("mrst_halt", 32'(halted), 0);
        clear_prog();
        for (int i = 0; i < 7; i++) prog[i] = enc(9, i + 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            cmp($sformatf("rst_r%0d", i + 1), 32'(display), 0);
        end

        // Fractional multiply, positive and negative
        clear_prog();
        prog[0] = enc(2, 1, 0, 8'h40);
        prog[1] = enc(4, 1, 0, 8'h40);
        prog[2] = enc(9, 1, 0, 0);
        prog[3] = enc(2, 1, 0, 8'h60);
        prog[4] = enc(4, 1, 0, 8'h40);
        prog[5] = enc(9, 1, 0, 0);
        prog[6] = enc(15, 0, 0, 0);
        do_reset();
        repeat (3) tick();
        cmp("muli_pos", 32'(display), 32'h20);
        repeat (3) tick();
        cmp("muli_neg", 32'(display), 32'hC0);

        // WAIT handshake
        clear_prog();
        prog[0]  = enc(2, 1, 0, 1);
        prog[1]  = enc(2, 2, 0, 2);
        prog[3]  = enc(6, 0, 0, 0);
        prog[4]  = enc(9, 1, 0, 0);
        prog[10] = enc(6, 0, 0, 0);
        prog[11] = enc(9, 2, 0, 0);
        prog[12] = enc(15, 0, 0, 0);
        sw8 = 1'b1;
        do_reset();
        repeat (4) tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            cmp("hold_pc", 32'(prog_addr), 3);
            cmp("hold_wait", 32'(waiting), 1);
        end
        sw8 = 1'b0;
        tick();
        cmp("k_wait", 32'(waiting), 1);
        tick();
        cmp("k1_wait", 32'(waiting), 1);
        cmp("k1_pc", 32'(prog_addr), 3);
        tick();
        cmp("k2_pc", 32'(prog_addr), 4);
        cmp("k2_wait", 32'(waiting), 0);
        sw8 = 1'b1;
        tick();
        sw8 = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            cmp("w2_pc", 32'(prog_addr), 10);
            cmp("w2_wait", 32'(waiting), 1);
        end
        sw8 = 1'b1;
        repeat (2) tick();
        sw8 = 1'b0;
        repeat (5) tick();
        cmp("w2_disp", 32'(display), 2);
        cmp("w2_halt", 32'(halted), 1);

        // BEQ loop and JMP wrap
        clear_prog();
        prog[0] = enc(2, 2, 0, 3);
        prog[1] = enc(2, 1, 0, 1);
        prog[2] = enc(7, 1, 2, 4);
        prog[3] = enc(8, 0, 0, 1);
        prog[4] = enc(9, 1, 0, 0);
        prog[5] = enc(8, 0, 0, 31);
        do_reset();
        repeat (9) tick();
        cmp("beq_pc", 32'(prog_addr), 4);
        cmp("beq_disp0", 32'(display), 0);
        tick();
        cmp("beq_disp", 32'(display), 3);
        tick();
        cmp("jmp_pc", 32'(prog_addr), 31);
        tick();
        cmp("wrap_pc", 32'(prog_addr), 0);

        // LDSW, DISP, HALT
        clear_prog();
        prog[0] = enc(5, 3, 0, 0);
        prog[1] = enc(9, 3, 0, 0);
        prog[2] = enc(15, 0, 0, 0);
        sw = 8'hA5;
        do_reset();
        repeat (3) tick();
        cmp("ldsw_disp", 32'(display), 32'hA5);
        cmp("halt_flag", 32'(halted), 1);
        for (int i = 0; i < 10; i++) begin
            sw8 = ~sw8;
            tick();
            cmp("halt_pc", 32'(prog_addr), 2);
        end
        do_reset();
        cmp("halt_clr", 32'(halted), 0);

        // Random programs and inputs against the model
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++) begin
                prog[i] = 18'($urandom_range(0, 18'h3FFFF));
                if (prog[i][17:14] == 4'hF && $urandom_range(0, 3) != 0)
                    prog[i][17:14] = 4'h0;
            end
            sw8 = 1'b1;
            do_reset();
            for (int c = 0; c < 200; c++) begin
                sw = 8'($urandom);
                if ($urandom_range(0, 2) == 0) sw8 = ~sw8;
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
